// File: rtl/harmonic_peak_search_pkg.sv
// rtl/harmonic_peak_search_pkg.sv - shared sizes and FSM encoding for the harmonic peak search
package harmonic_peak_search_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int N_HARM = 5;
    localparam int BIN_LO = 2;
    localparam int BIN_HI = 2047;
    localparam int WIN    = 2;
    localparam int C_W    = ADDR_W + 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FUND   = 3'd1;
    localparam logic [2:0] ST_FDRAIN = 3'd2;
    localparam logic [2:0] ST_HSETUP = 3'd3;
    localparam logic [2:0] ST_HSCAN  = 3'd4;
    localparam logic [2:0] ST_HDRAIN = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FUND   = ST_FUND,
        FDRAIN = ST_FDRAIN,
        HSETUP = ST_HSETUP,
        HSCAN  = ST_HSCAN,
        HDRAIN = ST_HDRAIN,
        FIN    = ST_FIN
    } state_t;

endpackage

// File: rtl/harmonic_peak_search_peak_tracker.sv
// rtl/harmonic_peak_search_peak_tracker.sv - running max of (bin, magnitude) pairs
module peak_tracker
    import harmonic_peak_search_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [ADDR_W-1:0] bin,
    input  logic [DATA_W-1:0] mag,
    output logic [ADDR_W-1:0] max_bin,
    output logic [DATA_W-1:0] max_mag
);

    logic r_empty;

    // The first datum after a clear is always taken so an all-zero window reports its lowest bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_bin <= '0;
            max_mag <= '0;
            r_empty <= 1'b1;
        end else if (clear) begin
            max_bin <= '0;
            max_mag <= '0;
            r_empty <= 1'b1;
        end else if (valid && (r_empty || (mag > max_mag))) begin
            max_bin <= bin;
            max_mag <= mag;
            r_empty <= 1'b0;
        end
    end

endmodule

// File: rtl/harmonic_peak_search.sv
// rtl/harmonic_peak_search.sv - fundamental and harmonic peak locator over the FFT magnitude RAM
module harmonic_peak_search
    import harmonic_peak_search_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [DATA_W-1:0]        ram_data,
    output logic                     busy,
    output logic                     done,
    output logic [N_HARM*ADDR_W-1:0] peak_bin,
    output logic [N_HARM*DATA_W-1:0] peak_mag
);

    localparam logic [2:0] K_LAST = 3'(N_HARM);

    state_t                   r_state;
    logic [ADDR_W-1:0]        r_addr;
    logic [ADDR_W-1:0]        r_hi;
    logic [ADDR_W-1:0]        r_f0;
    logic [ADDR_W-1:0]        r_dbin;
    logic                     r_vld;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pend;
    logic [2:0]               r_k;
    logic [2:0]               r_slot;
    logic [ADDR_W-1:0]        r_sh_bin [N_HARM];
    logic [DATA_W-1:0]        r_sh_mag [N_HARM];
    logic [N_HARM*ADDR_W-1:0] r_peak_bin;
    logic [N_HARM*DATA_W-1:0] r_peak_mag;

    logic                     w_clear;
    logic [ADDR_W-1:0]        w_max_bin;
    logic [DATA_W-1:0]        w_max_mag;
    logic [ADDR_W-1:0]        w_f0;
    logic [C_W-1:0]           w_c;
    logic [C_W-1:0]           w_hi_c;
    logic                     w_oob;
    logic [ADDR_W-1:0]        w_lo;
    logic [ADDR_W-1:0]        w_hi;
    logic [ADDR_W-1:0]        w_sh_bin_nx [N_HARM];
    logic [DATA_W-1:0]        w_sh_mag_nx [N_HARM];

    assign ram_addr = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign peak_bin = r_peak_bin;
    assign peak_mag = r_peak_mag;

    assign w_clear = ((r_state == IDLE) && start) || (r_state == HSETUP);

    peak_tracker u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .valid   (r_vld),
        .bin     (r_dbin),
        .mag     (ram_data),
        .max_bin (w_max_bin),
        .max_mag (w_max_mag)
    );

    // The tracker settles one edge after a drain, so k=2 reads f0 straight from it.
    assign w_f0   = (r_k == 3'd2) ? w_max_bin : r_f0;
    assign w_c    = C_W'(r_k) * C_W'(w_f0);
    assign w_hi_c = w_c + C_W'(WIN);
    assign w_oob  = w_c > C_W'(BIN_HI + WIN);
    assign w_lo   = (w_c < C_W'(BIN_LO + WIN)) ? ADDR_W'(BIN_LO) : ADDR_W'(w_c - C_W'(WIN));
    assign w_hi   = (w_hi_c > C_W'(BIN_HI)) ? ADDR_W'(BIN_HI) : ADDR_W'(w_hi_c);

    always_comb begin
        for (int i = 0; i < N_HARM; i++) begin
            w_sh_bin_nx[i] = r_sh_bin[i];
            w_sh_mag_nx[i] = r_sh_mag[i];
        end
        if (r_pend) begin
            w_sh_bin_nx[r_slot] = w_max_bin;
            w_sh_mag_nx[r_slot] = w_max_mag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_hi       <= '0;
            r_f0       <= '0;
            r_dbin     <= '0;
            r_vld      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pend     <= 1'b0;
            r_k        <= 3'd2;
            r_slot     <= 3'd0;
            r_peak_bin <= '0;
            r_peak_mag <= '0;
            for (int i = 0; i < N_HARM; i++) begin
                r_sh_bin[i] <= '0;
                r_sh_mag[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_vld  <= (r_state == FUND) || (r_state == HSCAN);
            r_dbin <= r_addr;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FUND;
                        r_busy  <= 1'b1;
                        r_addr  <= ADDR_W'(BIN_LO);
                    end
                end
                FUND: begin
                    if (r_addr == ADDR_W'(BIN_HI)) r_state <= FDRAIN;
                    else                            r_addr  <= r_addr + 1'b1;
                end
                FDRAIN: begin
                    r_pend  <= 1'b1;
                    r_slot  <= 3'd0;
                    r_k     <= 3'd2;
                    r_state <= HSETUP;
                end
                HSETUP: begin
                    r_pend <= 1'b0;
                    r_f0   <= w_f0;
                    for (int i = 0; i < N_HARM; i++) begin
                        r_sh_bin[i] <= w_sh_bin_nx[i];
                        r_sh_mag[i] <= w_sh_mag_nx[i];
                    end
                    if (w_oob) begin
                        r_sh_bin[r_k - 3'd1] <= '0;
                        r_sh_mag[r_k - 3'd1] <= '0;
                        if (r_k == K_LAST) r_state <= FIN;
                        else               r_k     <= r_k + 3'd1;
                    end else begin
                        r_addr  <= w_lo;
                        r_hi    <= w_hi;
                        r_slot  <= r_k - 3'd1;
                        r_state <= HSCAN;
                    end
                end
                HSCAN: begin
                    if (r_addr == r_hi) r_state <= HDRAIN;
                    else                r_addr  <= r_addr + 1'b1;
                end
                HDRAIN: begin
                    r_pend <= 1'b1;
                    if (r_k == K_LAST) begin
                        r_state <= FIN;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_state <= HSETUP;
                    end
                end
                FIN: begin
                    r_pend <= 1'b0;
                    for (int i = 0; i < N_HARM; i++) begin
                        r_peak_bin[i*ADDR_W +: ADDR_W] <= w_sh_bin_nx[i];
                        r_peak_mag[i*DATA_W +: DATA_W] <= w_sh_mag_nx[i];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_peak_search.sv
// tb/tb_harmonic_peak_search.sv - scoreboard bench for harmonic_peak_search
module tb_harmonic_peak_search;
    import harmonic_peak_search_pkg::*;

    localparam int BW = N_HARM * ADDR_W;
    localparam int MW = N_HARM * DATA_W;

    typedef struct {
        logic [BW-1:0] bin;
        logic [MW-1:0] mag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic          busy;
    logic          done;
    logic [BW-1:0] peak_bin;
    logic [MW-1:0] peak_mag;

    logic [DATA_W-1:0] mem [4096];
    exp_t sb[$];
    exp_t mon_e;
    exp_t no_hold;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ram_data <= mem[ram_addr];

    harmonic_peak_search dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy),
        .done     (done),
        .peak_bin (peak_bin),
        .peak_mag (peak_mag)
    );

    always @(negedge clk) begin
        if (!rst && done) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1, required no done");
            end else begin
                mon_e = sb.pop_front();
                if (peak_bin !== mon_e.bin) begin
                    n_fail++;
                    $display("FAIL done_peak_bin: got %h, required %h", peak_bin, mon_e.bin);
                end
                n_tests++;
                if (peak_mag !== mon_e.mag) begin
                    n_fail++;
                    $display("FAIL done_peak_mag: got %h, required %h", peak_mag, mon_e.mag);
                end
            end
        end
    end

    function automatic exp_t mk(input int b1, input int b2, input int b3, input int b4, input int b5,
                                input int m1, input int m2, input int m3, input int m4, input int m5);
        exp_t e;
        int b [N_HARM];
        int m [N_HARM];
        b[0] = b1; b[1] = b2; b[2] = b3; b[3] = b4; b[4] = b5;
        m[0] = m1; m[1] = m2; m[2] = m3; m[3] = m4; m[4] = m5;
        for (int i = 0; i < N_HARM; i++) begin
            e.bin[i*ADDR_W +: ADDR_W] = ADDR_W'(b[i]);
            e.mag[i*DATA_W +: DATA_W] = DATA_W'(m[i]);
        end
        return e;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    endtask

    task automatic random_mem(input int maxv);
        for (int i = 0; i < 4096; i++) mem[i] = DATA_W'($urandom_range(0, maxv));
    endtask

    task automatic model_scan(output exp_t e, output int lat);
        int f0, c, lo, hi, bb, mm;
        e.bin = '0;
        e.mag = '0;
        f0 = 0;
        lat = BIN_HI - BIN_LO + 1 + 3;
        for (int k = 1; k <= N_HARM; k++) begin
            if (k == 1) begin
                lo = BIN_LO;
                hi = BIN_HI;
            end else begin
                c = k * f0;
                if (c - WIN > BIN_HI) begin
                    lat += 1;
                    continue;
                end
                lo = (c - WIN < BIN_LO) ? BIN_LO : c - WIN;
                hi = (c + WIN > BIN_HI) ? BIN_HI : c + WIN;
                lat += hi - lo + 3;
            end
            bb = lo;
            mm = int'(mem[lo]);
            for (int i = lo + 1; i <= hi; i++) begin
                if (int'(mem[i]) > mm) begin
                    bb = i;
                    mm = int'(mem[i]);
                end
            end
            if (k == 1) f0 = bb;
            e.bin[(k-1)*ADDR_W +: ADDR_W] = ADDR_W'(bb);
            e.mag[(k-1)*DATA_W +: DATA_W] = DATA_W'(mm);
        end
    endtask

    task automatic run_scan(input int exp_lat, input string name, input bit hold_chk, input exp_t hold);
        int lat;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_rise: got %b, required 1", name, busy);
        end
        while (!done && lat < 5000) begin
            if (hold_chk && (lat == 1000 || lat == exp_lat - 1)) begin
                n_tests++;
                if (peak_bin !== hold.bin || peak_mag !== hold.mag) begin
                    n_fail++;
                    $display("FAIL %s_hold_c%0d: got %h/%h, required %h/%h",
                             name, lat, peak_bin, peak_mag, hold.bin, hold.mag);
                end
            end
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_fall: got %b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (ram_addr !== '0 || busy !== 1'b0 || done !== 1'b0 || peak_bin !== '0 || peak_mag !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%0d busy=%b done=%b bin=%h mag=%h, required all 0",
                     ram_addr, busy, done, peak_bin, peak_mag);
        end
        rst = 1'b0;
    endtask

    task automatic test_tone();
        clear_mem();
        mem[40] = 1000; mem[80] = 100; mem[120] = 50; mem[160] = 25; mem[200] = 10;
        sb.push_back(mk(40, 80, 120, 160, 200, 1000, 100, 50, 25, 10));
        run_scan(2077, "tone", 1'b0, no_hold);
    endtask

    task automatic test_shifted();
        clear_mem();
        mem[40] = 1000; mem[82] = 90; mem[123] = 70; mem[120] = 5;
        sb.push_back(mk(40, 82, 120, 158, 198, 1000, 90, 5, 0, 0));
        run_scan(2077, "shifted", 1'b0, no_hold);
    endtask

    task automatic test_high_fund();
        clear_mem();
        mem[600] = 800;
        sb.push_back(mk(600, 1198, 1798, 0, 0, 800, 0, 0, 0, 0));
        run_scan(2065, "high_fund", 1'b0, no_hold);
    endtask

    task automatic test_ties();
        clear_mem();
        mem[0] = 16'hFFFF; mem[1] = 16'hFFFF; mem[40] = 500; mem[41] = 500;
        sb.push_back(mk(40, 78, 118, 158, 198, 500, 0, 0, 0, 0));
        run_scan(2077, "ties", 1'b0, no_hold);
    endtask

    task automatic test_control();
        int lat;
        exp_t e;
        clear_mem();
        mem[40] = 1000; mem[80] = 100; mem[120] = 50; mem[160] = 25; mem[200] = 10;
        sb.push_back(mk(40, 80, 120, 160, 200, 1000, 100, 50, 25, 10));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 1;
        repeat (500) begin @(negedge clk); lat++; end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat++;
        while (!done && lat < 5000) begin @(negedge clk); lat++; end
        n_tests++;
        if (lat !== 2077) begin
            n_fail++;
            $display("FAIL ctrl_ignore_latency: got %0d, required 2077", lat);
        end
        repeat (2200) @(negedge clk);

        random_mem(150);
        mem[50] = 2500;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (999) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (ram_addr !== '0 || busy !== 1'b0 || done !== 1'b0 || peak_bin !== '0 || peak_mag !== '0) begin
            n_fail++;
            $display("FAIL ctrl_midscan_reset: got addr=%0d busy=%b done=%b bin=%h mag=%h, required all 0",
                     ram_addr, busy, done, peak_bin, peak_mag);
        end
        @(negedge clk) rst = 1'b0;
        repeat (2200) @(negedge clk);
        n_tests++;
        if (peak_bin !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_after_reset_idle: got bin=%h busy=%b, required 0/0", peak_bin, busy);
        end
        model_scan(e, lat);
        sb.push_back(e);
        run_scan(lat, "ctrl_restart", 1'b0, no_hold);
    endtask

    task automatic test_back_to_back();
        exp_t ea, eb;
        int la, lb;
        random_mem(200);
        mem[97] = 4000;
        model_scan(ea, la);
        sb.push_back(ea);
        run_scan(la, "b2b_first", 1'b0, no_hold);
        random_mem(150);
        mem[450] = 3000;
        model_scan(eb, lb);
        sb.push_back(eb);
        run_scan(lb, "b2b_second", 1'b1, ea);
    endtask

    initial begin
        no_hold.bin = '0;
        no_hold.mag = '0;
        clear_mem();
        test_reset();
        test_tone();
        test_shifted();
        test_high_fund();
        test_ties();
        test_control();
        test_back_to_back();
        repeat (5) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
